// File: rtl/rtc_init_sequencer.sv
// Self-timed RTC init sequencer: walks an (address, data) table on the muxed RTC bus.
// Optional read-back/compare after every write is enabled by defining RTC_INIT_READBACK_EN.
module rtc_init_sequencer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_WRITES = 4,
   parameter int unsigned SLOT_LEN   = 24,
   parameter int unsigned SETUP      = 2,
   parameter logic [NUM_WRITES*DATA_W-1:0] INIT_ADDR = 32'h00_10_02_02,
   parameter logic [NUM_WRITES*DATA_W-1:0] INIT_DATA = 32'h10_D2_00_10,
   localparam int unsigned IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              start,
   input  logic [DATA_W-1:0] rtc_din,
   output logic              en_dir,
   output logic              en_wr,
   output logic              en_rd,
   output logic [DATA_W-1:0] data_rtc,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  idx,
   output logic              err
);

   localparam int unsigned      CNT_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WRITES - 1);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      GAP_A,
      WRITE,
      GAP_W,
`ifdef RTC_INIT_READBACK_EN
      RD_ADDR,
      GAP_RA,
      READ,
      GAP_R,
`endif
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              dir_nxt, wr_nxt, busy_nxt, done_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              err_clr, err_set;

   logic [DATA_W-1:0] addr_tab [NUM_WRITES];
   logic [DATA_W-1:0] data_tab [NUM_WRITES];

   // Unflatten the parameter tables; entry 0 sits in the LSBs
   for (genvar g = 0; g < NUM_WRITES; g++) begin : g_tab
      assign addr_tab[g] = INIT_ADDR[g*DATA_W +: DATA_W];
      assign data_tab[g] = INIT_DATA[g*DATA_W +: DATA_W];
   end

   // Next-state, slot counter and table index
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      err_clr   = 1'b0;
      err_set   = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = ADDR;
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
                  err_clr   = 1'b1;
               end
            end
            DONE: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
            default: begin
               if (cnt != CNT_LAST) begin
                  cnt_nxt = cnt + 1'b1;
               end else begin
                  cnt_nxt = '0;
                  case (state)
                     ADDR:    state_nxt = GAP_A;
                     GAP_A:   state_nxt = WRITE;
                     WRITE:   state_nxt = GAP_W;
`ifdef RTC_INIT_READBACK_EN
                     GAP_W:   state_nxt = RD_ADDR;
                     RD_ADDR: state_nxt = GAP_RA;
                     GAP_RA:  state_nxt = READ;
                     READ: begin
                        state_nxt = GAP_R;
                        err_set   = (rtc_din != data_tab[idx]);
                     end
                     GAP_R: begin
`else
                     GAP_W: begin
`endif
                        if (idx == IDX_LAST) begin
                           state_nxt = DONE;
                        end else begin
                           idx_nxt   = idx + 1'b1;
                           state_nxt = ADDR;
                        end
                     end
                     default: state_nxt = IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // Output values for the coming cycle, derived from the next state so they align with it
   always_comb begin
`ifdef RTC_INIT_READBACK_EN
      dir_nxt = (state_nxt == ADDR) || (state_nxt == RD_ADDR);
`else
      dir_nxt = (state_nxt == ADDR);
`endif
      wr_nxt   = (state_nxt == WRITE);
      busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
      done_nxt = (state_nxt == DONE);
      data_nxt = '0;
      if (cnt_nxt >= CNT_SETUP) begin
         if (dir_nxt) begin
            data_nxt = addr_tab[idx_nxt];
         end else if (wr_nxt) begin
            data_nxt = data_tab[idx_nxt];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         en_dir   <= 1'b0;
         en_wr    <= 1'b0;
         data_rtc <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         en_dir   <= dir_nxt;
         en_wr    <= wr_nxt;
         data_rtc <= data_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

`ifdef RTC_INIT_READBACK_EN
   // err survives an en abort; only reset or a newly accepted run clears it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_rd <= 1'b0;
         err   <= 1'b0;
      end else begin
         en_rd <= (state_nxt == READ);
         if (err_clr) begin
            err <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
      end
   end
`else
   logic unused_rb;
   assign unused_rb = ^{rtc_din, err_clr, err_set};
   assign en_rd     = 1'b0;
   assign err       = 1'b0;
`endif

endmodule

// File: doc/rtc_init_sequencer.md
Name: rtc_init_sequencer

Overview:
- Parametrised, self-timed successor to the fixed-count RTC initialisation block.
- Owns its own slot/transaction counters and walks a parameter-defined table of (address, data) writes on the multiplexed address/data RTC bus.
- Per entry, drives the `en_dir` (address phase) and `en_wr` (write phase) strobes plus `data_rtc`.
- Sits between the top-level control FSM (`start`/`done` handshake) and the RTC bus driver.

Parameters:
- DATA_W, 8, width of `data_rtc` and of each table entry
- NUM_WRITES, 4, number of table entries written per run (1..16)
- SLOT_LEN, 24, cycles per phase slot (strobe-high or gap); must be > SETUP+1
- SETUP, 2, cycles from strobe rise to `data_rtc` becoming valid
- INIT_ADDR, 32'h00_10_02_02, flattened NUM_WRITES*DATA_W address table; entry 0 in LSBs
- INIT_DATA, 32'h10_D2_00_10, flattened NUM_WRITES*DATA_W data table; entry 0 in LSBs

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  block enable; low aborts and holds all outputs at 0
- start  in  1  request a run; sampled only in IDLE with `en`=1
- rtc_din  in  DATA_W  bus read data (used only with the optional feature)
- en_dir  out  1  address-phase strobe
- en_wr  out  1  write-phase strobe
- en_rd  out  1  read-phase strobe (tied 0 without the optional feature)
- data_rtc  out  DATA_W  value presented to the bus driver
- busy  out  1  high from the accepted start through the final slot
- done  out  1  one-cycle pulse at the end of a completed run
- idx  out  clog2(NUM_WRITES) or 1  current table entry
- err  out  1  sticky readback mismatch (0 without the optional feature)

Behaviour:
- Reset (`reset`=0, asynchronous): state IDLE; all outputs 0; slot counter 0; `idx` 0.
- States: IDLE, ADDR, GAP_A, WRITE, GAP_W, DONE; each non-IDLE/DONE state lasts exactly SLOT_LEN cycles.
- Start: in IDLE, `en`=1 and `start`=1 at edge k → state ADDR and `busy`=1 after edge k.
  - Call the edge that enters a slot s; the slot counter counts 0..SLOT_LEN-1.
- ADDR: `en_dir`=1 after edge s; `data_rtc`=INIT_ADDR[idx] after edge s+SETUP.
- GAP_A: entered at edge s+SLOT_LEN; `en_dir`=0 and `data_rtc`=0 after that edge.
- WRITE: `en_wr`=1 after its entry edge; `data_rtc`=INIT_DATA[idx] after entry+SETUP.
- GAP_W: strobes and data return to 0.
  - At the end of GAP_W, if `idx`<NUM_WRITES-1: `idx`++ and go to ADDR.
  - Otherwise go to DONE.
- Transaction length is 4*SLOT_LEN cycles.
- DONE: single cycle. `done`=1 and `busy`=0 after its entry edge, then IDLE. With defaults, DONE is entered at edge k+384.
- `en_dir` and `en_wr` are never high simultaneously; outside strobe slots `data_rtc` is 0.
- `start` while not IDLE: ignored; no queuing.
- `en`=0 in any state: next edge forces IDLE, all outputs 0, `idx` 0, no `done` pulse; `err` preserved.
- `start` with `en`=0: ignored.
- Reset mid-run: immediate abort to reset values, including `err`.
- NUM_WRITES=1: `idx` is a constant 0; the run is one transaction.

Optional Feature:
- Macro: RTC_INIT_READBACK_EN.
- Defined: after each GAP_W, insert RD_ADDR (`en_dir`, `data_rtc`=INIT_ADDR[idx], same timing as ADDR), then GAP_RA, then READ, then GAP_R.
  - READ: `en_rd`=1 and `data_rtc`=0.
  - `rtc_din` is sampled on the last READ cycle and compared with INIT_DATA[idx]; a mismatch sets `err` (sticky until reset or the next accepted start).
  - Transaction length becomes 8*SLOT_LEN.
- Undefined: read states absent; `en_rd` and `err` are constant 0; `rtc_din` unused.

Test Plan:
- Defaults; reset released, `start` pulsed at edge k → `en_dir` high edges k..k+23; `data_rtc`=0x02 after k+2; `en_wr` high k+48..k+71 with `data_rtc`=0x10 after k+50; `done` pulses after k+384, `busy` drops the same edge.
- Full run → observed (addr,data) pairs are (02,10), (02,00), (10,D2), (00,10) in order; `idx` 0→3.
- `start` reasserted at k+100 mid-run → ignored; single `done` at k+384.
- `en` dropped at k+150 → after the next edge all outputs 0 and IDLE, no `done`; new `start` restarts from `idx` 0.
- `reset` asserted at k+60 asynchronously → outputs 0 immediately without waiting for a clock edge.
- With RTC_INIT_READBACK_EN, `rtc_din` returns 0xD1 for entry 2 → `err`=1 after the entry-2 READ; `done` after k+768.
